seq_divider: RTL and testbench

//   Multi-cycle unsigned restoring divider. It is the inverse operation to the
//   MAC multiplier datapath. It consumes a dividend/divisor pair and returns the

---
 rtl/seq_divider.sv | 140 ++++++++++++++
 tb/tb_seq_divider.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Multi-cycle unsigned restoring divider, one shift-subtract
//               step per clock, with a start/ready/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz
);

    localparam int c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH:0]     r_prem;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_dz;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH:0]     w_shifted;
    logic [WIDTH+1:0]   w_diff;
    logic               w_qbit;
    logic [WIDTH:0]     w_prem_next;
    logic [WIDTH-1:0]   w_shreg_next;
    logic               w_unused;

    // The extra guard bit keeps the borrow visible: shifted can reach 2*divisor-1.
    assign w_shifted    = {r_prem[WIDTH-1:0], r_shreg[WIDTH-1]};
    assign w_diff       = {1'b0, w_shifted} - {2'b00, r_divisor};
    assign w_qbit       = ~w_diff[WIDTH+1];
    assign w_prem_next  = w_qbit ? w_diff[WIDTH:0] : w_shifted;
    assign w_shreg_next = {r_shreg[WIDTH-2:0], w_qbit};
    assign w_last       = (r_count == c_last_iter);
    // Partial remainder stays below the divisor, so its top bit is never read.
    assign w_unused     = r_prem[WIDTH];

    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign dz        = r_dz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        done         = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = (divisor == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = (divisor == '0) ? S_DONE : S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_prem      <= '0;
            r_shreg     <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dz        <= 1'b0;
        end else if (w_accept) begin
            r_divisor <= divisor;
            r_count   <= '0;
            r_prem    <= '0;
            r_shreg   <= dividend;
            r_dz      <= 1'b0;
            // Divide-by-zero skips the iteration and publishes at once.
            if (divisor == '0) begin
                r_quotient  <= '1;
                r_remainder <= dividend;
                r_dz        <= 1'b1;
            end
        end else if (r_state == S_RUN) begin
            r_prem  <= w_prem_next;
            r_shreg <= w_shreg_next;
            r_count <= r_count + c_cnt_w'(1);
            if (w_last) begin
                r_quotient  <= w_shreg_next;
                r_remainder <= w_prem_next[WIDTH-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Directed vector table plus hand-written handshake sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       ready;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       dz;

    int total;
    int bad;

    seq_divider #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        int         lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Accept at the next edge, then count edges until done (bounded).
    task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] q, output logic [7:0] r,
                           output logic z, output int lat, output logic ready_ok);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'hA5;
        divisor  = 8'h5A;
        lat      = 0;
        ready_ok = 1'b1;
        while (!done && lat < 20) begin
            if (ready) ready_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        q = quotient;
        r = remainder;
        z = dz;
    endtask

    initial begin
        logic [7:0] q, r, a, b;
        logic       z, rok;
        int         lat, npulse;

        total = 0;
        bad   = 0;
        start = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        rst_n = 1'b0;

        vecs[0]  = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 8};
        vecs[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8};
        vecs[2]  = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 8};
        vecs[3]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 8};
        vecs[4]  = '{8'd0,   8'd3,   8'd0,   8'd0,   1'b0, 8};
        vecs[5]  = '{8'd100, 8'd0,   8'd255, 8'd100, 1'b1, 0};
        vecs[6]  = '{8'd9,   8'd3,   8'd3,   8'd0,   1'b0, 8};
        vecs[7]  = '{8'd17,  8'd5,   8'd3,   8'd2,   1'b0, 8};
        vecs[8]  = '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0, 8};
        vecs[9]  = '{8'd128, 8'd16,  8'd8,   8'd0,   1'b0, 8};
        vecs[10] = '{8'd0,   8'd0,   8'd255, 8'd0,   1'b1, 0};
        vecs[11] = '{8'd254, 8'd127, 8'd2,   8'd0,   1'b0, 8};

        #12;
        check("reset_ready", ready, 1);
        check("reset_done", done, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_dz", dz, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_div(vecs[i].a, vecs[i].b, q, r, z, lat, rok);
            check($sformatf("vec%0d_quotient", i), q, vecs[i].q);
            check($sformatf("vec%0d_remainder", i), r, vecs[i].r);
            check($sformatf("vec%0d_dz", i), z, vecs[i].z);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_ready_low_in_run", i), rok, 1);
        end

        // Starts during RUN are dropped, not queued.
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 8'd7;
        @(negedge clk);
        start = 1'b0;
        npulse = 0;
        q = 8'd0; r = 8'd0;
        for (int l = 0; l < 14; l++) begin
            if (done) begin
                npulse++;
                q = quotient;
                r = remainder;
            end
            if (l == 3 || l == 6) begin
                start = 1'b1; dividend = 8'd1; divisor = 8'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("ignore_start_pulses", npulse, 1);
        check("ignore_start_quotient", q, 28);
        check("ignore_start_remainder", r, 4);

        // Back-to-back accept in the done cycle.
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 8'd7;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_first_latency", lat, 8);
        check("b2b_first_quotient", quotient, 28);
        start = 1'b1; dividend = 8'd50; divisor = 8'd6;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        rok = 1'b1;
        while (!done && lat < 20) begin
            if (ready) rok = 1'b0;
            if (lat == 4) check("b2b_hold_quotient", quotient, 28);
            @(negedge clk);
            lat++;
        end
        check("b2b_second_latency", lat, 8);
        check("b2b_no_idle_gap", rok, 1);
        check("b2b_second_quotient", quotient, 8);
        check("b2b_second_remainder", remainder, 2);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ready", ready, 1);
        check("abort_done", done, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_dz", dz, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        npulse = 0;
        for (int l = 0; l < 12; l++) begin
            if (done) npulse++;
            @(negedge clk);
        end
        check("abort_no_done", npulse, 0);
        run_div(8'd17, 8'd5, q, r, z, lat, rok);
        check("after_abort_quotient", q, 3);
        check("after_abort_remainder", r, 2);
        check("after_abort_latency", lat, 8);

        // Random operand pairs against plain arithmetic.
        for (int k = 0; k < 200; k++) begin
            a = 8'($urandom_range(0, 255));
            b = (k % 25 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            run_div(a, b, q, r, z, lat, rok);
            if (b == 8'd0) begin
                check($sformatf("rand%0d_q_%0d_%0d", k, a, b), q, 255);
                check($sformatf("rand%0d_r_%0d_%0d", k, a, b), r, a);
                check($sformatf("rand%0d_dz_%0d_%0d", k, a, b), z, 1);
            end else begin
                check($sformatf("rand%0d_q_%0d_%0d", k, a, b), q, a / b);
                check($sformatf("rand%0d_r_%0d_%0d", k, a, b), r, a % b);
                check($sformatf("rand%0d_dz_%0d_%0d", k, a, b), z, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
